gmii_rx_frame_checker: RTL and testbench
========================================

Name: gmii_rx_frame_checker

Overview:
Synthesizable GMII receive-side frame checker. It sits between the SGMII PCS receive path (the GMII RxD/RxDV/RxER producer) and the MAC-side consumer. It strips the preamble and SFD, and forwards frame bytes (FCS included) as a framed byte stream with 1-cycle latency. It checks the CRC-32, length and error propagation, and keeps good/bad frame counters.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes after SFD, FCS included
MAX_FRAME, 1518, maximum legal frame length in bytes after SFD, FCS included
LEN_W, 14, width of the length output; must hold MAX_FRAME

Ports:
i_Clk  in  1  GMII receive clock, 125 MHz; all logic on rising edge
i_Reset  in  1  asynchronous, active-high reset
i8_RxD  in  8  GMII receive data
i_RxDV  in  1  GMII receive data valid
i_RxER  in  1  GMII receive error; with RxDV=0 this is carrier extension/error, ignored here
o8_Data  out  8  frame byte
o_Valid  out  1  o8_Data valid
o_Sop  out  1  first byte after SFD; qualified by o_Valid
o_Eop  out  1  last forwarded byte; qualified by o_Valid
o_StatusValid  out  1  one-cycle pulse carrying frame status
o_CrcOk  out  1  CRC residue correct
o_ErrFlag  out  1  RxDV=1 & RxER=1 seen in frame
o_Runt  out  1  length < MIN_FRAME
o_Giant  out  1  frame exceeded MAX_FRAME and was truncated
o_NoSfd  out  1  carrier ended or bad byte before SFD
oN_Length  out  LEN_W  bytes forwarded, including FCS
o32_GoodFrames  out  32  count of frames with CrcOk & !ErrFlag & !Runt & !Giant
o32_BadFrames  out  32  count of all other frames that reached DATA

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, counters 0, CRC = 0xFFFFFFFF.
  - FSM goes to WAIT_END, so a frame already in progress at release is never picked up.
- FSM states: IDLE, PREAMBLE, DATA, DROP, WAIT_END.
- IDLE, on RxDV=1:
  - RxD=0x55 -> PREAMBLE.
  - RxD=0xD5 -> DATA (SFD-only preamble accepted).
  - Other byte -> WAIT_END, and pulse StatusValid with NoSfd=1.
- PREAMBLE:
  - RxDV=1 & 0x55 -> stay.
  - RxDV=1 & 0xD5 -> DATA; clear CRC, count and flags.
  - RxDV=1 & other byte -> WAIT_END with NoSfd pulse.
  - RxDV=0 -> IDLE with NoSfd pulse.
  - NoSfd events touch neither counter.
- DATA, byte capture and forwarding:
  - Each RxDV=1 byte is captured into a 1-byte hold register and updates the CRC.
  - A held byte is driven on o8_Data with o_Valid=1 in the cycle the next byte arrives, so latency is 1 cycle.
  - o_Sop is asserted with the first forwarded byte.
- DATA, RxER during frame: RxDV=1 & RxER=1 sets the error flag; the byte is still forwarded.
- DATA, end of frame (RxDV falls), all in one cycle:
  - Drive the held byte with o_Eop=1.
  - Pulse o_StatusValid with all flags and oN_Length.
  - Increment exactly one counter.
  - Go to IDLE.
  - The cycle after RxDV falls may itself carry RxDV=1 with 0x55; it is accepted as a new preamble.
- Giant:
  - Arrival of byte MAX_FRAME+1 does the following in that cycle:
    - Drive the held byte (byte MAX_FRAME) with o_Eop=1.
    - Status pulse with Giant=1, CrcOk=0, Length=MAX_FRAME.
    - Increment BadFrames.
    - Go to DROP.
  - DROP forwards nothing and leaves on RxDV=0 -> IDLE.
- Zero-length frame (SFD then RxDV=0):
  - No o_Valid.
  - Status pulse with Length=0, Runt=1, CrcOk=0.
  - BadFrames+1.
- WAIT_END: discards everything; RxDV=0 -> IDLE.
- CRC-32:
  - Reflected polynomial 0xEDB88320, LSB first, init 0xFFFFFFFF.
  - Computed over all bytes after the SFD, FCS included.
  - CrcOk=1 iff the register equals residue 0xDEBB20E3 after the final byte.
- Status outputs:
  - Flags and oN_Length hold their value until the next StatusValid pulse.
  - o_Valid, o_Sop, o_Eop and o_StatusValid are single-cycle pulses.
- Arithmetic:
  - Counters wrap modulo 2^32.
  - The length counter cannot exceed MAX_FRAME because of truncation.
- Carrier extension/error codes (RxDV=0, RxER=1) in any state: treated as RxDV=0.

Test Plan:
- Good frame: 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 64 Valid bytes, each 1 cycle after input; Sop on byte 1; Eop on byte 64 in the cycle RxDV falls; StatusValid with CrcOk=1, Length=64; GoodFrames=1.
- Same frame with payload byte 10 XOR 0x01 -> CrcOk=0, GoodFrames unchanged, BadFrames=1.
- Good 64-byte frame with RxDV=1 & RxER=1 on byte 20 -> 64 bytes forwarded; ErrFlag=1, CrcOk=1; BadFrames+1.
- 40-byte frame with valid FCS -> Runt=1, CrcOk=1, Length=40, BadFrames+1. A 1600-byte frame -> Eop on byte 1518, Giant=1, Length=1518, no further Valid until the next frame.
- Preamble 3x0x55 then 0x12 -> NoSfd pulse, no Valid, counters unchanged. Back-to-back good frames with 1 idle cycle between -> both counted good.
- i_Reset asserted at byte 30 of a frame and released while RxDV=1 -> outputs 0 immediately, no Valid for the rest of that frame; the next good frame yields GoodFrames=1.

Source files
------------

// File: rtl/gmii_rx_frame_checker.sv
// GMII receive frame checker: strips preamble/SFD, forwards frame bytes with FCS,
// and reports CRC-32, length and error status per frame with good/bad counters.
module gmii_rx_frame_checker #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned LEN_W     = 14
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic [7:0]       i8_RxD,
  input  logic             i_RxDV,
  input  logic             i_RxER,
  output logic [7:0]       o8_Data,
  output logic             o_Valid,
  output logic             o_Sop,
  output logic             o_Eop,
  output logic             o_StatusValid,
  output logic             o_CrcOk,
  output logic             o_ErrFlag,
  output logic             o_Runt,
  output logic             o_Giant,
  output logic             o_NoSfd,
  output logic [LEN_W-1:0] oN_Length,
  output logic [31:0]      o32_GoodFrames,
  output logic [31:0]      o32_BadFrames
);

  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
  localparam logic [7:0]       PRE_BYTE    = 8'h55;
  localparam logic [7:0]       SFD_BYTE    = 8'hD5;
  localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP,
    S_WAIT_END
  } state_e;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      crc_q, crc_d;
  logic             err_q, err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             stat_q, stat_d;
  logic             crc_ok_q, crc_ok_d;
  logic             errflag_q, errflag_d;
  logic             runt_q, runt_d;
  logic             giant_q, giant_d;
  logic             nosfd_q, nosfd_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [31:0]      good_q, good_d;
  logic [31:0]      bad_q, bad_d;

  logic start, capture, end_frame, trunc, no_sfd, frame_good;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    len_d      = len_q;
    crc_d      = crc_q;
    err_d      = err_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    stat_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    errflag_d  = errflag_q;
    runt_d     = runt_q;
    giant_d    = giant_q;
    nosfd_d    = nosfd_q;
    length_d   = length_q;
    good_d     = good_q;
    bad_d      = bad_q;
    start      = 1'b0;
    capture    = 1'b0;
    end_frame  = 1'b0;
    trunc      = 1'b0;
    no_sfd     = 1'b0;
    frame_good = 1'b0;

    // RxER without RxDV is carrier extension and is deliberately ignored.
    unique case (state_q)
      S_IDLE: begin
        if (i_RxDV) begin
          if (i8_RxD == PRE_BYTE) begin
            state_d = S_PREAMBLE;
          end else if (i8_RxD == SFD_BYTE) begin
            state_d = S_DATA;
            start   = 1'b1;
          end else begin
            state_d = S_WAIT_END;
            no_sfd  = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (!i_RxDV) begin
          state_d = S_IDLE;
          no_sfd  = 1'b1;
        end else if (i8_RxD == SFD_BYTE) begin
          state_d = S_DATA;
          start   = 1'b1;
        end else if (i8_RxD != PRE_BYTE) begin
          state_d = S_WAIT_END;
          no_sfd  = 1'b1;
        end
      end
      S_DATA: begin
        if (!i_RxDV) begin
          state_d   = S_IDLE;
          end_frame = 1'b1;
        end else if (len_q == MAX_LEN) begin
          state_d = S_DROP;
          trunc   = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      S_DROP, S_WAIT_END: begin
        if (!i_RxDV) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_WAIT_END;
    endcase

    if (start) begin
      crc_d = CRC_INIT;
      len_d = '0;
      err_d = 1'b0;
    end

    if (capture) begin
      hold_d = i8_RxD;
      crc_d  = crc_byte(crc_q, i8_RxD);
      len_d  = len_q + LEN_W'(1);
      if (i_RxER) begin
        err_d = 1'b1;
      end
    end

    // The held byte is released once the next byte (or end of carrier) shows up.
    if ((capture || end_frame || trunc) && (len_q != '0)) begin
      valid_d = 1'b1;
      data_d  = hold_q;
      sop_d   = (len_q == LEN_W'(1));
      eop_d   = end_frame || trunc;
    end

    if (end_frame || trunc) begin
      stat_d     = 1'b1;
      crc_ok_d   = end_frame && (len_q != '0) && (crc_q == CRC_RESIDUE);
      errflag_d  = err_q;
      runt_d     = (len_q < MIN_LEN);
      giant_d    = trunc;
      nosfd_d    = 1'b0;
      length_d   = len_q;
      frame_good = crc_ok_d && !err_q && !runt_d && !trunc;
      if (frame_good) begin
        good_d = good_q + 32'd1;
      end else begin
        bad_d = bad_q + 32'd1;
      end
    end

    if (no_sfd) begin
      stat_d    = 1'b1;
      crc_ok_d  = 1'b0;
      errflag_d = 1'b0;
      runt_d    = 1'b0;
      giant_d   = 1'b0;
      nosfd_d   = 1'b1;
      length_d  = '0;
    end
  end

  // Reset parks in WAIT_END so a frame already on the wire is ignored.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_WAIT_END;
      hold_q    <= '0;
      len_q     <= '0;
      crc_q     <= CRC_INIT;
      err_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      stat_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      errflag_q <= 1'b0;
      runt_q    <= 1'b0;
      giant_q   <= 1'b0;
      nosfd_q   <= 1'b0;
      length_q  <= '0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      stat_q    <= stat_d;
      crc_ok_q  <= crc_ok_d;
      errflag_q <= errflag_d;
      runt_q    <= runt_d;
      giant_q   <= giant_d;
      nosfd_q   <= nosfd_d;
      length_q  <= length_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  assign o8_Data        = data_q;
  assign o_Valid        = valid_q;
  assign o_Sop          = sop_q;
  assign o_Eop          = eop_q;
  assign o_StatusValid  = stat_q;
  assign o_CrcOk        = crc_ok_q;
  assign o_ErrFlag      = errflag_q;
  assign o_Runt         = runt_q;
  assign o_Giant        = giant_q;
  assign o_NoSfd        = nosfd_q;
  assign oN_Length      = length_q;
  assign o32_GoodFrames = good_q;
  assign o32_BadFrames  = bad_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Bench for gmii_rx_frame_checker: table of frame cases plus hand-built corner
// sequences, with byte and status scoreboards stamped with the expected cycle.
module tb_gmii_rx_frame_checker;

  localparam int unsigned MIN_FRAME = 64;
  localparam int unsigned MAX_FRAME = 1518;
  localparam int unsigned LEN_W     = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rxd;
  logic             rxdv;
  logic             rxer;
  logic [7:0]       o8_Data;
  logic             o_Valid, o_Sop, o_Eop, o_StatusValid;
  logic             o_CrcOk, o_ErrFlag, o_Runt, o_Giant, o_NoSfd;
  logic [LEN_W-1:0] oN_Length;
  logic [31:0]      o32_GoodFrames, o32_BadFrames;

  gmii_rx_frame_checker #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .LEN_W(LEN_W)) dut (
    .i_Clk(clk), .i_Reset(rst), .i8_RxD(rxd), .i_RxDV(rxdv), .i_RxER(rxer),
    .o8_Data(o8_Data), .o_Valid(o_Valid), .o_Sop(o_Sop), .o_Eop(o_Eop),
    .o_StatusValid(o_StatusValid), .o_CrcOk(o_CrcOk), .o_ErrFlag(o_ErrFlag),
    .o_Runt(o_Runt), .o_Giant(o_Giant), .o_NoSfd(o_NoSfd), .oN_Length(oN_Length),
    .o32_GoodFrames(o32_GoodFrames), .o32_BadFrames(o32_BadFrames)
  );

  always #4 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] data; logic sop; logic eop; int unsigned cyc; } exp_byte_t;
  typedef struct { logic crc_ok; logic err; logic runt; logic giant; logic nosfd;
                   int unsigned len; int unsigned cyc; } exp_stat_t;
  typedef struct { int pre; int paylen; bit fcs; int flip; int er;
                   logic crc_ok; logic err; logic runt; logic giant; int unsigned len; } vec_t;

  exp_byte_t   byte_q[$];
  exp_stat_t   stat_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_good = 0;
  int unsigned exp_bad  = 0;
  vec_t        tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-reflected MSB-first CRC with bit-reversed input; result mapped to the wire FCS.
  function automatic logic [31:0] fcs_of(input bq_t q);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ q[k][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    for (int b = 0; b < 32; b++) r[b] = ~c[31-b];
    return r;
  endfunction

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    rxd  = b;
    rxdv = dv;
    rxer = er;
    @(posedge clk);
    #1;
  endtask

  task automatic push_stat(input logic c, input logic e, input logic r, input logic g,
                           input logic n, input int unsigned len);
    exp_stat_t s;
    s = '{c, e, r, g, n, len, cyc + 1};
    stat_q.push_back(s);
  endtask

  task automatic send_frame(input int pre, input bq_t bytes, input int er_idx,
                            input logic c, input logic e, input logic r, input logic g,
                            input int unsigned len);
    int        n;
    int        fwd;
    exp_byte_t eb;
    n   = bytes.size();
    fwd = (n > int'(MAX_FRAME)) ? int'(MAX_FRAME) : n;
    for (int i = 0; i < pre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i < fwd) begin
        eb = '{bytes[i], i == 0, i == fwd - 1, cyc + 2};
        byte_q.push_back(eb);
      end
      if (i == int'(MAX_FRAME)) push_stat(c, e, r, g, 1'b0, len);
      drive(bytes[i], 1'b1, i == er_idx);
    end
    if (n <= int'(MAX_FRAME)) push_stat(c, e, r, g, 1'b0, len);
    drive(8'h00, 1'b0, 1'b0);
    if (c && !e && !r && !g) exp_good++;
    else exp_bad++;
  endtask

  function automatic bq_t make_frame(input int paylen, input bit fcs, input int flip);
    bq_t         q;
    logic [31:0] f;
    logic [7:0]  t;
    for (int i = 0; i < paylen; i++) q.push_back(8'($urandom_range(0, 255)));
    if (fcs) begin
      f = fcs_of(q);
      q.push_back(f[7:0]);
      q.push_back(f[15:8]);
      q.push_back(f[23:16]);
      q.push_back(f[31:24]);
    end
    if (flip >= 0) begin
      t       = q[flip];
      q[flip] = t ^ 8'h01;
    end
    return q;
  endfunction

  task automatic idle(input int n);
    // RxER with RxDV low (carrier extension) must be ignored.
    for (int i = 0; i < n; i++) drive(8'h0F, 1'b0, i[0]);
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_good"}, {32'd0, o32_GoodFrames}, {32'd0, exp_good});
    chk({name, "_bad"}, {32'd0, o32_BadFrames}, {32'd0, exp_bad});
    chk({name, "_drain"}, 64'(byte_q.size() + stat_q.size()), 64'd0);
  endtask

  task automatic monitor();
    exp_byte_t eb;
    exp_stat_t es;
    forever begin
      @(negedge clk);
      if (o_Valid) begin
        if (byte_q.size() == 0) begin
          chk("unexpected_valid", {56'd0, o8_Data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          eb = byte_q.pop_front();
          chk("data_byte", {16'd0, o8_Data, 6'd0, o_Sop, o_Eop, cyc},
              {16'd0, eb.data, 6'd0, eb.sop, eb.eop, eb.cyc});
        end
      end
      if (o_StatusValid) begin
        if (stat_q.size() == 0) begin
          chk("unexpected_status", {48'd0, 16'(oN_Length)}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          es = stat_q.pop_front();
          chk("status", {o_CrcOk, o_ErrFlag, o_Runt, o_Giant, o_NoSfd, 11'd0, 16'(oN_Length), cyc},
              {es.crc_ok, es.err, es.runt, es.giant, es.nosfd, 11'd0, 16'(es.len), es.cyc});
        end
      end
    end
  endtask

  initial begin
    bq_t q;
    tbl[0]  = '{7, 60,   1'b1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 64};
    tbl[1]  = '{7, 60,   1'b1,  9, -1, 1'b0, 1'b0, 1'b0, 1'b0, 64};
    tbl[2]  = '{7, 60,   1'b1, -1, 19, 1'b1, 1'b1, 1'b0, 1'b0, 64};
    tbl[3]  = '{7, 36,   1'b1, -1, -1, 1'b1, 1'b0, 1'b1, 1'b0, 40};
    tbl[4]  = '{7, 1596, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1518};
    tbl[5]  = '{0, 60,   1'b1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 64};
    tbl[6]  = '{7, 59,   1'b1, -1, -1, 1'b1, 1'b0, 1'b1, 1'b0, 63};
    tbl[7]  = '{7, 1514, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1518};
    tbl[8]  = '{7, 1515, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1518};
    tbl[9]  = '{2, 0,    1'b0, -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[10] = '{1, 1,    1'b0, -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1};

    rst  = 1'b1;
    rxd  = 8'h00;
    rxdv = 1'b0;
    rxer = 1'b0;
    #2;
    chk("reset_pulses", {59'd0, o_Valid, o_Sop, o_Eop, o_StatusValid, 1'b0}, 64'd0);
    chk("reset_flags", {51'd0, o_CrcOk, o_ErrFlag, o_Runt, o_Giant, o_NoSfd, o8_Data}, 64'd0);
    chk("reset_len", {48'd0, 16'(oN_Length)}, 64'd0);
    chk("reset_counters", {o32_GoodFrames, o32_BadFrames}, 64'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    fork
      monitor();
    join_none

    idle(3);
    for (int t = 0; t < 11; t++) begin
      q = make_frame(tbl[t].paylen, tbl[t].fcs, tbl[t].flip);
      send_frame(tbl[t].pre, q, tbl[t].er, tbl[t].crc_ok, tbl[t].err, tbl[t].runt,
                 tbl[t].giant, tbl[t].len);
      idle(4);
      chk_counters($sformatf("case%0d", t));
    end

    // Preamble broken by a bad byte: NoSfd, rest of the burst discarded.
    for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
    push_stat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    drive(8'h12, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    drive(8'h34, 1'b1, 1'b0);
    idle(4);
    chk_counters("nosfd_pre");

    // Non-preamble byte straight from idle.
    push_stat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    drive(8'h12, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    idle(4);
    chk_counters("nosfd_idle");

    // Carrier drops during preamble.
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    push_stat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    drive(8'h00, 1'b0, 1'b0);
    idle(4);
    chk_counters("nosfd_dvfall");

    // Back-to-back good frames: only the RxDV-low cycle separates them.
    q = make_frame(60, 1'b1, -1);
    send_frame(7, q, -1, 1'b1, 1'b0, 1'b0, 1'b0, 64);
    q = make_frame(70, 1'b1, -1);
    send_frame(7, q, -1, 1'b1, 1'b0, 1'b0, 1'b0, 74);
    idle(4);
    chk_counters("back_to_back");

    // Reset mid-frame, released while RxDV is still high.
    q = make_frame(60, 1'b1, -1);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 29; i++) begin
      byte_q.push_back('{q[i], i == 0, 1'b0, cyc + 2});
      drive(q[i], 1'b1, 1'b0);
    end
    rst = 1'b1;
    byte_q.delete();
    stat_q.delete();
    #1;
    chk("mid_reset_outputs", {o8_Data, o_Valid, o_Sop, o_Eop, o_StatusValid, o_CrcOk, o_Giant, 16'(oN_Length), 30'd0},
        64'd0);
    chk("mid_reset_counters", {o32_GoodFrames, o32_BadFrames}, 64'd0);
    exp_good = 0;
    exp_bad  = 0;
    for (int i = 29; i < 32; i++) drive(q[i], 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 32; i < 64; i++) drive(q[i], 1'b1, 1'b0);
    idle(4);
    chk_counters("after_reset");
    q = make_frame(60, 1'b1, -1);
    send_frame(7, q, -1, 1'b1, 1'b0, 1'b0, 1'b0, 64);
    idle(4);
    chk_counters("post_reset_good");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
